pic_inta_sequencer: RTL and testbench

// - Interrupt-acknowledge control stage directly downstream of Priority_resolver in the 8259-style PIC.
// - Consumes the resolver's winning request level, raises INT to the CPU, runs the 8086-style two-pulse INTA handshake and drives the vector byte on the data bus.
// - Owns the in-service register (ISR), IRR bit-clear strobes and end-of-interrupt (EOI) handling.

---
 rtl/pic_inta_sequencer.sv | 168 ++++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_inta_sequencer.sv
// 8259-style interrupt-acknowledge sequencer: INT/INTA handshake, vector drive, ISR and EOI handling.
// Optional automatic EOI is enabled by defining PIC_AEOI_EN.
module pic_inta_sequencer #(
    parameter int INTA_TIMEOUT = 255,
    parameter int SPUR_LEVEL   = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [2:0] req_level,
    input  logic       inta_n,
    input  logic [4:0] vec_base,
    input  logic       eoi_strobe,
    input  logic       eoi_spec,
    input  logic [2:0] eoi_level,
    output logic       int_out,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [7:0] isr,
    output logic [7:0] irr_clr
);

    localparam int CNT_W = (INTA_TIMEOUT > 0) ? $clog2(INTA_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(INTA_TIMEOUT);
    localparam logic [2:0] SPUR_LVL = 3'(SPUR_LEVEL);

`ifdef PIC_AEOI_EN
    localparam bit AEOI = 1'b1;
`else
    localparam bit AEOI = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        ACK1,
        WAIT2,
        ACK2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             inta_prev;
    logic             inta_fall;
    logic             inta_rise;
    logic             int_next;
    logic             oe_next;
    logic [7:0]       data_next;
    logic [2:0]       lvl;
    logic [2:0]       lvl_next;
    logic             lvl_real;
    logic             real_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [7:0]       set_mask;
    logic [7:0]       aeoi_mask;
    logic [7:0]       eoi_mask;
    logic [7:0]       isr_next;

    assign inta_fall = inta_prev & ~inta_n;
    assign inta_rise = ~inta_prev & inta_n;

    always_comb begin
        state_next = state;
        int_next   = int_out;
        oe_next    = data_oe;
        data_next  = data_out;
        lvl_next   = lvl;
        real_next  = lvl_real;
        cnt_next   = cnt;
        set_mask   = 8'h00;
        aeoi_mask  = 8'h00;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    int_next   = 1'b1;
                    state_next = PEND;
                end
            end
            PEND: begin
                // A request that vanished before the first INTA is acknowledged as spurious.
                if (inta_fall) begin
                    state_next = ACK1;
                    real_next  = req_valid;
                    if (req_valid) begin
                        lvl_next = req_level;
                        set_mask = 8'h01 << req_level;
                    end else begin
                        lvl_next = SPUR_LVL;
                    end
                end
            end
            ACK1: begin
                if (inta_rise) begin
                    int_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = WAIT2;
                end
            end
            WAIT2: begin
                if (inta_fall) begin
                    state_next = ACK2;
                    oe_next    = 1'b1;
                    data_next  = {vec_base, lvl};
                end else begin
                    cnt_next = cnt + 1'b1;
                    if (INTA_TIMEOUT != 0 && cnt_next == TIMEOUT_VAL) begin
                        state_next = IDLE;
                    end
                end
            end
            ACK2: begin
                // Spurious acknowledges never set an ISR bit, so automatic EOI must not clear one.
                if (inta_rise) begin
                    state_next = IDLE;
                    oe_next    = 1'b0;
                    data_next  = 8'h00;
                    if (AEOI && lvl_real) begin
                        aeoi_mask = 8'h01 << lvl;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Clears first, then the new in-service bit, so a same-cycle set wins.
    always_comb begin
        eoi_mask = 8'h00;
        if (eoi_strobe) begin
            if (eoi_spec) begin
                eoi_mask = 8'h01 << eoi_level;
            end else begin
                eoi_mask = isr & (~isr + 8'h01);
            end
        end
        isr_next = (isr & ~(eoi_mask | aeoi_mask)) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            inta_prev <= 1'b1;
            int_out   <= 1'b0;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
            isr       <= 8'h00;
            irr_clr   <= 8'h00;
            lvl       <= 3'd0;
            lvl_real  <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            inta_prev <= inta_n;
            int_out   <= int_next;
            data_out  <= data_next;
            data_oe   <= oe_next;
            isr       <= isr_next;
            irr_clr   <= set_mask;
            lvl       <= lvl_next;
            lvl_real  <= real_next;
            cnt       <= cnt_next;
        end
    end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench for pic_inta_sequencer: randomized INTA handshakes against a transaction-level ISR model.
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] req_level;
    logic       inta_n;
    logic [4:0] vec_base;
    logic       eoi_strobe;
    logic       eoi_spec;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] isr;
    logic [7:0] irr_clr;

    int checks = 0;
    int failures = 0;

`ifdef PIC_AEOI_EN
    localparam bit AEOI = 1'b1;
`else
    localparam bit AEOI = 1'b0;
`endif

    always #5 clk = ~clk;

    pic_inta_sequencer #(.INTA_TIMEOUT(4), .SPUR_LEVEL(7)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_level(req_level),
        .inta_n(inta_n), .vec_base(vec_base), .eoi_strobe(eoi_strobe), .eoi_spec(eoi_spec),
        .eoi_level(eoi_level), .int_out(int_out), .data_out(data_out), .data_oe(data_oe),
        .isr(isr), .irr_clr(irr_clr)
    );

    // Reference model state and the expectations of the latest handshake.
    logic [7:0] m_isr;
    logic [7:0] e_irr, e_isr_f1, e_data, e_isr_exit;
    // Observations of the latest handshake.
    logic       o_int_acc, o_int_ack1, o_oe_ack1, o_int_wait, o_oe_wait;
    logic       o_oe_ack2, o_stable, o_oe_exit, o_int_exit;
    logic [7:0] o_irr_f1, o_irr_after, o_isr_f1, o_data, o_isr_exit;

    function automatic logic [7:0] model_eoi(input logic [7:0] cur, input logic spec, input logic [2:0] lv);
        logic [7:0] r;
        r = cur;
        if (spec) r[lv] = 1'b0;
        else begin
            for (int i = 0; i < 8; i++) begin
                if (r[i]) begin
                    r[i] = 1'b0;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_eoi(input logic spec, input logic [2:0] lv);
        eoi_strobe = 1'b1; eoi_spec = spec; eoi_level = lv;
        tick;
        eoi_strobe = 1'b0;
        m_isr = model_eoi(m_isr, spec, lv);
    endtask

    // Full two-pulse handshake with random pulse widths and gaps; records observations and model expectations.
    task automatic run_seq(input logic [2:0] lv, input logic [4:0] base, input logic spur,
                           input logic eoi_f1, input logic eoi_sp, input logic [2:0] eoi_lv, input logic hold_req);
        logic [2:0] exp_lvl;
        exp_lvl = spur ? 3'd7 : lv;
        vec_base = base; req_valid = 1'b1; req_level = lv;
        tick;
        o_int_acc = int_out;
        if (spur) req_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick;
        inta_n = 1'b0;
        if (eoi_f1) begin
            eoi_strobe = 1'b1; eoi_spec = eoi_sp; eoi_level = eoi_lv;
            m_isr = model_eoi(m_isr, eoi_sp, eoi_lv);
        end
        tick;
        eoi_strobe = 1'b0;
        if (!spur) m_isr = m_isr | (8'h01 << lv);
        e_irr = spur ? 8'h00 : (8'h01 << lv);
        e_isr_f1 = m_isr;
        e_data = {base, exp_lvl};
        o_irr_f1 = irr_clr; o_isr_f1 = isr; o_oe_ack1 = data_oe;
        if (!hold_req) req_valid = 1'b0;
        req_level = 3'($urandom);
        tick;
        o_irr_after = irr_clr; o_oe_ack1 = o_oe_ack1 | data_oe;
        repeat ($urandom_range(0, 2)) begin
            tick;
            o_oe_ack1 = o_oe_ack1 | data_oe;
        end
        o_int_ack1 = int_out;
        inta_n = 1'b1;
        tick;
        o_int_wait = int_out; o_oe_wait = data_oe;
        repeat ($urandom_range(0, 2)) begin
            tick;
            o_oe_wait = o_oe_wait | data_oe;
        end
        inta_n = 1'b0;
        tick;
        o_oe_ack2 = data_oe; o_data = data_out; o_stable = 1'b1;
        repeat ($urandom_range(0, 2)) begin
            tick;
            o_oe_ack2 = o_oe_ack2 & data_oe;
            if (data_out !== o_data) o_stable = 1'b0;
        end
        inta_n = 1'b1;
        tick;
        if (AEOI && !spur) m_isr = m_isr & ~(8'h01 << lv);
        e_isr_exit = m_isr;
        o_oe_exit = data_oe; o_int_exit = int_out; o_isr_exit = isr;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick; tick;
        checks++; if (int_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_int_out got=%b exp=0", int_out); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_data_out got=%h exp=00", data_out); end
        checks++; if (data_oe !== 1'b0) begin failures++; $display("[TB] FAIL reset_data_oe got=%b exp=0", data_oe); end
        checks++; if (isr !== 8'h00) begin failures++; $display("[TB] FAIL reset_isr got=%h exp=00", isr); end
        checks++; if (irr_clr !== 8'h00) begin failures++; $display("[TB] FAIL reset_irr_clr got=%h exp=00", irr_clr); end
        rst_n = 1'b1;
        m_isr = 8'h00;
        tick;
    endtask

    task automatic test_basic;
        run_seq(3'd3, 5'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        checks++; if (o_int_acc !== 1'b1) begin failures++; $display("[TB] FAIL basic_int_raise got=%b exp=1", o_int_acc); end
        checks++; if (o_int_ack1 !== 1'b1) begin failures++; $display("[TB] FAIL basic_int_hold got=%b exp=1", o_int_ack1); end
        checks++; if (o_int_wait !== 1'b0) begin failures++; $display("[TB] FAIL basic_int_drop got=%b exp=0", o_int_wait); end
        checks++; if (o_irr_f1 !== e_irr) begin failures++; $display("[TB] FAIL basic_irr_clr got=%h exp=%h", o_irr_f1, e_irr); end
        checks++; if (o_irr_after !== 8'h00) begin failures++; $display("[TB] FAIL basic_irr_pulse got=%h exp=00", o_irr_after); end
        checks++; if (o_isr_f1 !== e_isr_f1) begin failures++; $display("[TB] FAIL basic_isr got=%h exp=%h", o_isr_f1, e_isr_f1); end
        checks++; if (o_oe_ack1 !== 1'b0 || o_oe_wait !== 1'b0) begin failures++; $display("[TB] FAIL basic_oe_early got=%b%b exp=00", o_oe_ack1, o_oe_wait); end
        checks++; if (o_oe_ack2 !== 1'b1) begin failures++; $display("[TB] FAIL basic_oe_ack2 got=%b exp=1", o_oe_ack2); end
        checks++; if (o_data !== e_data || o_data !== 8'h43) begin failures++; $display("[TB] FAIL basic_vector got=%h exp=%h", o_data, e_data); end
        checks++; if (o_oe_exit !== 1'b0) begin failures++; $display("[TB] FAIL basic_oe_exit got=%b exp=0", o_oe_exit); end
        checks++; if (o_isr_exit !== e_isr_exit) begin failures++; $display("[TB] FAIL basic_isr_exit got=%h exp=%h", o_isr_exit, e_isr_exit); end
    endtask

    task automatic test_spurious;
        run_seq(3'd1, 5'h08, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        checks++; if (o_int_ack1 !== 1'b1) begin failures++; $display("[TB] FAIL spur_int_hold got=%b exp=1", o_int_ack1); end
        checks++; if (o_irr_f1 !== 8'h00) begin failures++; $display("[TB] FAIL spur_irr_clr got=%h exp=00", o_irr_f1); end
        checks++; if (o_isr_f1 !== e_isr_f1) begin failures++; $display("[TB] FAIL spur_isr got=%h exp=%h", o_isr_f1, e_isr_f1); end
        checks++; if (o_data !== 8'h47) begin failures++; $display("[TB] FAIL spur_vector got=%h exp=47", o_data); end
        checks++; if (o_isr_exit !== e_isr_exit) begin failures++; $display("[TB] FAIL spur_isr_exit got=%h exp=%h", o_isr_exit, e_isr_exit); end
    endtask

    task automatic test_eoi;
        for (int i = 0; i < 8; i++) do_eoi(1'b1, 3'(i));
        checks++; if (isr !== m_isr) begin failures++; $display("[TB] FAIL eoi_clear_all got=%h exp=%h", isr, m_isr); end
        run_seq(3'd5, 5'h10, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        run_seq(3'd3, 5'h10, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        checks++; if (isr !== m_isr) begin failures++; $display("[TB] FAIL eoi_setup got=%h exp=%h", isr, m_isr); end
        do_eoi(1'b0, 3'd6);
        checks++; if (isr !== m_isr) begin failures++; $display("[TB] FAIL eoi_nonspecific got=%h exp=%h", isr, m_isr); end
        do_eoi(1'b1, 3'd5);
        checks++; if (isr !== m_isr) begin failures++; $display("[TB] FAIL eoi_specific got=%h exp=%h", isr, m_isr); end
        do_eoi(1'b0, 3'd2);
        checks++; if (isr !== 8'h00) begin failures++; $display("[TB] FAIL eoi_empty got=%h exp=00", isr); end
        // Same-cycle clear and set of one bit must leave the bit set.
        run_seq(3'd6, 5'h02, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        run_seq(3'd6, 5'h02, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        checks++; if (o_isr_f1 !== e_isr_f1) begin failures++; $display("[TB] FAIL eoi_collide_ns got=%h exp=%h", o_isr_f1, e_isr_f1); end
        run_seq(3'd4, 5'h02, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0);
        checks++; if (o_isr_f1 !== e_isr_f1) begin failures++; $display("[TB] FAIL eoi_collide_sp got=%h exp=%h", o_isr_f1, e_isr_f1); end
    endtask

    task automatic test_random;
        logic [2:0] lv;
        logic [4:0] base;
        logic       spur;
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 2) == 0) do_eoi(1'($urandom), 3'($urandom));
            lv = 3'($urandom); base = 5'($urandom); spur = ($urandom_range(0, 3) == 0);
            run_seq(lv, base, spur, 1'b0, 1'b0, 3'd0, 1'b0);
            checks++; if (o_irr_f1 !== e_irr) begin failures++; $display("[TB] FAIL rnd_irr_clr n=%0d got=%h exp=%h", n, o_irr_f1, e_irr); end
            checks++; if (o_isr_f1 !== e_isr_f1) begin failures++; $display("[TB] FAIL rnd_isr n=%0d got=%h exp=%h", n, o_isr_f1, e_isr_f1); end
            checks++; if (o_data !== e_data || o_stable !== 1'b1) begin failures++; $display("[TB] FAIL rnd_vector n=%0d got=%h stable=%b exp=%h", n, o_data, o_stable, e_data); end
            checks++; if (o_oe_ack1 | o_oe_wait | ~o_oe_ack2 | o_oe_exit) begin failures++; $display("[TB] FAIL rnd_oe n=%0d got=%b%b%b%b exp=0010", n, o_oe_ack1, o_oe_wait, o_oe_ack2, o_oe_exit); end
            checks++; if (o_int_wait !== 1'b0 || o_int_acc !== 1'b1) begin failures++; $display("[TB] FAIL rnd_int n=%0d got=%b%b exp=10", n, o_int_acc, o_int_wait); end
            checks++; if (o_isr_exit !== e_isr_exit) begin failures++; $display("[TB] FAIL rnd_isr_exit n=%0d got=%h exp=%h", n, o_isr_exit, e_isr_exit); end
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] lv;
        run_seq(3'd2, 5'h1f, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        checks++; if (o_int_exit !== 1'b0) begin failures++; $display("[TB] FAIL b2b_int_exit got=%b exp=0", o_int_exit); end
        lv = 3'($urandom);
        req_level = lv;
        tick;
        checks++; if (int_out !== 1'b1) begin failures++; $display("[TB] FAIL b2b_int_next got=%b exp=1", int_out); end
        run_seq(lv, 5'h0a, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        checks++; if (o_data !== e_data) begin failures++; $display("[TB] FAIL b2b_vector got=%h exp=%h", o_data, e_data); end
        checks++; if (o_isr_exit !== e_isr_exit) begin failures++; $display("[TB] FAIL b2b_isr got=%h exp=%h", o_isr_exit, e_isr_exit); end
    endtask

    task automatic test_timeout;
        logic [2:0] lv;
        logic       oe_seen;
        lv = 3'($urandom);
        oe_seen = 1'b0;
        vec_base = 5'h03; req_valid = 1'b1; req_level = lv;
        tick;
        inta_n = 1'b0;
        tick;
        m_isr = m_isr | (8'h01 << lv);
        inta_n = 1'b1;
        tick;
        // Request held high: it can only be taken once the sequencer is back in IDLE.
        for (int k = 1; k <= 4; k++) begin
            tick;
            oe_seen = oe_seen | data_oe;
            checks++; if (int_out !== 1'b0) begin failures++; $display("[TB] FAIL timeout_wait k=%0d got=%b exp=0", k, int_out); end
        end
        tick;
        oe_seen = oe_seen | data_oe;
        checks++; if (int_out !== 1'b1) begin failures++; $display("[TB] FAIL timeout_idle got=%b exp=1", int_out); end
        checks++; if (oe_seen !== 1'b0) begin failures++; $display("[TB] FAIL timeout_oe got=%b exp=0", oe_seen); end
        checks++; if (isr !== m_isr) begin failures++; $display("[TB] FAIL timeout_isr got=%h exp=%h", isr, m_isr); end
        req_valid = 1'b0; rst_n = 1'b0;
        tick;
        rst_n = 1'b1; m_isr = 8'h00;
        tick;
    endtask

    task automatic test_idle_inta;
        logic oe_seen;
        oe_seen = 1'b0;
        req_valid = 1'b0; inta_n = 1'b0;
        repeat (3) begin
            tick;
            oe_seen = oe_seen | data_oe | int_out;
        end
        inta_n = 1'b1;
        tick;
        checks++; if (oe_seen !== 1'b0) begin failures++; $display("[TB] FAIL idle_inta_oe got=%b exp=0", oe_seen); end
        checks++; if (isr !== m_isr || irr_clr !== 8'h00) begin failures++; $display("[TB] FAIL idle_inta_isr got=%h/%h exp=%h/00", isr, irr_clr, m_isr); end
        run_seq(3'd0, 5'h15, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        checks++; if (o_data !== e_data) begin failures++; $display("[TB] FAIL idle_inta_after got=%h exp=%h", o_data, e_data); end
    endtask

    task automatic test_reset_mid;
        vec_base = 5'h11; req_valid = 1'b1; req_level = 3'd6;
        tick;
        inta_n = 1'b0; tick;
        req_valid = 1'b0;
        inta_n = 1'b1; tick;
        inta_n = 1'b0; tick;
        checks++; if (data_oe !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_in_ack2 got=%b exp=1", data_oe); end
        rst_n = 1'b0;
        tick;
        checks++; if (data_oe !== 1'b0 || int_out !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_outs got=%b%b exp=00", data_oe, int_out); end
        checks++; if (isr !== 8'h00 || data_out !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_isr got=%h/%h exp=00/00", isr, data_out); end
        rst_n = 1'b1; inta_n = 1'b1; m_isr = 8'h00;
        tick;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_level = 3'd0; inta_n = 1'b1;
        vec_base = 5'h00; eoi_strobe = 1'b0; eoi_spec = 1'b0; eoi_level = 3'd0;
        m_isr = 8'h00;
        test_reset;
        test_basic;
        test_spurious;
        test_eoi;
        test_random;
        test_back_to_back;
        test_timeout;
        test_idle_inta;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
